// File: rtl/control_sequencer.sv
// Hardwired control unit: a Moore FSM that fetches over T0-T2 and executes over
// T3-T5, emitting one-hot register load (Rin) and bus drive (Rout) strobes.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  output logic [31:0] Rin,
  output logic [31:0] Rout,
  output logic        IRin,
  output logic        MARin,
  output logic        RZout,
  output logic        RYin,
  output logic        RBin,
  output logic        PCjump,
  output logic        MDRread,
  output logic [15:0] ALUControl,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE, T0, T1, T2, T3, T4, T5, HALT
  } state_e;

  localparam int unsigned Z_BIT   = 19;
  localparam int unsigned PC_BIT  = 20;
  localparam int unsigned MDR_BIT = 21;

  localparam logic [4:0]  OP_NEG  = 5'd6;
  localparam logic [4:0]  OP_NOT  = 5'd7;
  localparam logic [4:0]  OP_JR   = 5'd8;
  localparam logic [4:0]  OP_HALT = 5'd31;
  localparam logic [15:0] ALU_PC_INC = 16'd15;

  state_e      state_q, state_d;
  logic [16:0] ir_q;          // opcode/Ra/Rb/Rc only; IR[14:0] is never decoded
  logic        unused_ir;

  assign unused_ir = ^IR[14:0];

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_three_op, is_two_op;
  state_e     boundary_state;

  assign opcode      = ir_q[16:12];
  assign ra          = ir_q[11:8];
  assign rb          = ir_q[7:4];
  assign rc          = ir_q[3:0];
  assign is_three_op = (opcode <= 5'd5);
  assign is_two_op   = (opcode == OP_NEG) || (opcode == OP_NOT);
  // run is only consulted here, so an instruction in flight always completes.
  assign boundary_state = run ? T0 : IDLE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the IR latch is reset too so decode never sees X.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T2) ir_q <= IR[31:15];
    end
  end

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (run) state_d = T0;
      T0:   state_d = T1;
      T1:   state_d = T2;
      T2:   state_d = T3;
      T3: begin
        if (is_three_op || is_two_op) state_d = T4;
        else if (opcode == OP_HALT)   state_d = HALT;
        else                          state_d = boundary_state;
      end
      T4:   state_d = is_three_op ? T5 : boundary_state;
      T5:   state_d = boundary_state;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Rin        = '0;
    Rout       = '0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    RZout      = 1'b0;
    RYin       = 1'b0;
    RBin       = 1'b0;
    PCjump     = 1'b0;
    MDRread    = 1'b0;
    ALUControl = '0;
    halted     = 1'b0;
    case (state_q)
      T0: begin
        Rout[PC_BIT] = 1'b1;
        MARin        = 1'b1;
        Rin[Z_BIT]   = 1'b1;
        ALUControl   = ALU_PC_INC;
      end
      T1: begin
        Rout[Z_BIT]   = 1'b1;
        Rin[PC_BIT]   = 1'b1;
        Rin[MDR_BIT]  = 1'b1;
        MDRread       = 1'b1;
      end
      T2: begin
        Rout[MDR_BIT] = 1'b1;
        IRin          = 1'b1;
      end
      T3: begin
        if (is_three_op) begin
          Rout[rb] = 1'b1;
          RYin     = 1'b1;
        end else if (is_two_op) begin
          Rout[rb]   = 1'b1;
          Rin[Z_BIT] = 1'b1;
          ALUControl = {11'd0, opcode};
        end else if (opcode == OP_JR) begin
          Rout[rb]    = 1'b1;
          Rin[PC_BIT] = 1'b1;
          PCjump      = 1'b1;
        end
      end
      T4: begin
        if (is_three_op) begin
          Rout[rc]   = 1'b1;
          Rin[Z_BIT] = 1'b1;
          ALUControl = {11'd0, opcode};
        end else if (is_two_op) begin
          Rout[Z_BIT] = 1'b1;
          Rin[ra]     = 1'b1;
        end
      end
      T5: begin
        Rout[Z_BIT] = 1'b1;
        Rin[ra]     = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: clear  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: run  input  1  permits a new instruction fetch when high.
REQ-004 SHALL have port: IR  input  32  instruction register contents from the datapath.
REQ-005 SHALL have port: Rin  output  32  register-load strobes: [15:0] R0-R15, [19] Zlow/Zin, [20] PC, [21] MDR.
REQ-006 SHALL have port: Rout  output  32  bus-drive strobes, same bit map as Rin.
REQ-007 SHALL have ports: IRin, MARin, RZout, RYin, RBin, PCjump, MDRread  output  1 each  datapath strobes.
REQ-008 SHALL have port: ALUControl  output  16  ALU operation code.
REQ-009 SHALL have port: halted  output  1  high while in HALT.

Function
REQ-010 Moore FSM; all outputs SHALL be decoded from the current state and latched IR fields only, with one state per clock.
REQ-011 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, HALT.
REQ-012 IR fields SHALL be: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-013 Opcodes SHALL be: 0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shl, 6 neg, 7 not, 8 jr, 31 halt; all others are NOP.
REQ-014 For ALU opcodes 0-7, ALUControl SHALL equal the opcode zero-extended to 16 bits.
REQ-015 IDLE: all outputs 0; SHALL go to T0 when run=1, else stay in IDLE.
REQ-016 T0: Rout[20], MARin, Rin[19] asserted and ALUControl=16'd15 (PC increment); SHALL go to T1.
REQ-017 T1: Rout[19], Rin[20], MDRread, Rin[21] asserted; SHALL go to T2.
REQ-018 T2: Rout[21], IRin asserted; SHALL go to T3. IR SHALL be sampled for decode on entry to T3, not earlier.
REQ-019 Three-operand ops (0-5): T3 Rout[Rb], RYin; T4 Rout[Rc], ALUControl=op, Rin[19]; T5 Rout[19], Rin[Ra]; after T5, SHALL go to T0 if run=1, else IDLE.
REQ-020 Two-operand ops (6, 7): T3 Rout[Rb], ALUControl=op, Rin[19]; T4 Rout[19], Rin[Ra]; then SHALL go to T0 or IDLE per run; T5 is skipped.
REQ-021 jr (8): T3 Rout[Rb], Rin[20], PCjump; then SHALL go to T0 or IDLE per run.
REQ-022 NOP: T3 all outputs 0; then SHALL go to T0 or IDLE per run.
REQ-023 halt (31): T3 SHALL go to HALT; HALT drives all strobes 0 and halted=1, and is left only by clear.
REQ-024 At most one Rout bit SHALL be high in any cycle; Ra=Rb=Rc aliasing SHALL NOT alter sequencing.
REQ-025 RZout and RBin SHALL be held 0 (reserved).
REQ-026 run SHALL be sampled only at instruction boundaries (IDLE, last execute state); deasserting run mid-instruction SHALL NOT abort it.

Reset
REQ-027 clear=1 SHALL immediately force IDLE and drive all outputs 0, including halted, irrespective of clock.
REQ-028 Reset mid-instruction SHALL abandon the instruction; no further strobes are issued until run=1 after clear falls.
REQ-029 The first T0 SHALL occur on the first rising edge after clear=0 with run=1.

Verification
REQ-030 clear pulse during T4 -> all outputs 0 within the same cycle, state IDLE, no Rin[Ra] strobe follows.
REQ-031 run=1, IR=0x32380000 (neg R4,R7) -> T3: Rout[7], ALUControl=6, Rin[19]; T4: Rout[19], Rin[4]; next cycle T0.
REQ-032 IR=0x00918000 (add R1,R2,R3) -> T3: Rout[2], RYin; T4: Rout[3], ALUControl=0, Rin[19]; T5: Rout[19], Rin[1].
REQ-033 IR=0x40280000 (jr R5) -> T3: Rout[5], Rin[20], PCjump all 1; 4 cycles per instruction.
REQ-034 IR=0xF8000000 -> halted=1 from the cycle after T3, holds with run=1 for 10 cycles, and clears on clear.
REQ-035 All cycles: checker asserts popcount(Rout) <= 1 and that T0-T2 strobes match REQ-016 to REQ-018 exactly.
